ro_dep_scoreboard: RTL and testbench
====================================

Name: ro_dep_scoreboard

Overview:
- Per-register in-flight write scoreboard for the read-operands (RO) stage.
- Tracks outstanding writes to 8 GPRs, 8 MMX registers and 8 segment registers between RO issue and WB commit.
- Produces the RO dependency stall from registered counters, replacing wide EX/WB destination comparators.
- Sits beside the RO stall/valid logic. Its dep_stall feeds the V_ex gating.

Parameters:
- CNT_W, 2, width of each per-register in-flight counter; max count = 2^CNT_W-1.
- NREG, 8, entries per register class (GPR, MM, SEG); indices are 3 bits.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- V_ro  in  1  RO instruction valid.
- in3, in4  in  3 each  GPR source indices.
- in3_needed, in4_needed  in  1 each  source valids.
- eax_needed, ecx_needed  in  1 each  implicit GPR0/GPR1 sources.
- mm1, mm2  in  3 each  MM source indices.
- mm1_needed, mm2_needed  in  1 each  MM source valids.
- seg3  in  3  segment source index.
- seg3_needed  in  1  segment source valid.
- issue_fire  in  1  RO instruction moves to EX this cycle (V_ex & ld_ex).
- ro_dreg1, ro_dreg2, ro_dreg3  in  3 each  RO GPR destinations.
- ro_ld_reg1, ro_ld_reg2, ro_ld_reg3  in  1 each  RO GPR destination valids.
- ro_dmm, ro_ld_mm  in  3 / 1  RO MM destination and its valid.
- ro_dseg, ro_ld_seg  in  3 / 1  RO segment destination and its valid.
- wb_fire  in  1  WB commits this cycle.
- wb_dreg1..3, wb_ld_reg1..3, wb_dmm, wb_ld_mm, wb_dseg, wb_ld_seg  in  3/1  WB destinations and valids.
- flush  in  1  pipeline flush; all in-flight writes are squashed.
- dep_stall  out  1  RO source hazard or counter saturation.
- gpr_busy, mm_busy, seg_busy  out  8 each  per-register count != 0.
- sb_err  out  1  sticky underflow error.

Behaviour:
- Reset (async, rst=1):
  - All counters = 0.
  - sb_err = 0.
  - busy vectors = 0.
  - dep_stall = 0.
- Issue increment set:
  - Distinct registers among valid ro destinations, gated by issue_fire.
  - Duplicate destinations within one instruction (e.g. ro_dreg1==ro_dreg2, both valid) increment once.
- Retire decrement set:
  - Distinct registers among valid wb destinations, gated by wb_fire.
  - Same duplicate rule as issue.
- Per-counter next state, evaluated on posedge clk:
  - flush: 0. Flush overrides issue and retire in the same cycle.
  - Increment and decrement on the same register in the same cycle: count unchanged.
  - Increment only: count+1.
  - Decrement only with count>0: count-1.
  - Decrement only with count==0: count stays 0 and sb_err is set. sb_err clears only on rst.
- Hazard:
  - hazard = V_ro & OR over needed sources of busy[src].
  - eax_needed checks GPR0; ecx_needed checks GPR1.
  - Hazard uses registered counts only. There is no WB bypass: the stall releases the cycle after the retiring wb_fire edge.
- Saturation:
  - sat = V_ro & (any valid ro destination has count == 2^CNT_W-1).
- dep_stall:
  - dep_stall = hazard | sat.
  - Combinational from registered state and RO inputs; no clk-to-output latency beyond the counters.
- issue_fire asserted while dep_stall=1 is a protocol violation. The counters still update; no check is made.
- rst asserted mid-operation clears everything immediately; issue/retire pending at that moment is lost.
- Counter width: CNT_W; increment never wraps because sat blocks issue.

Decomposition:
- Shared package ro_pkg:
  - REG_IDX_W=3, NREG=8, GPR_EAX=3'd0, GPR_ECX=3'd1.
  - Typedef for a destination bundle {idx, valid}.
- One natural sub-module, ro_sb_counter:
  - One CNT_W counter with inc/dec/flush/underflow.
  - Instantiated 24 times.
- Top level holds:
  - one-hot decode with duplicate collapse;
  - source mux/OR;
  - sb_err flag.

Test Plan:
1. Reset then idle: rst pulse → all busy=0, dep_stall=0, sb_err=0, even with in3_needed=1, in3=5, V_ro=1.
2. RAW on GPR: issue_fire with ro_dreg1=3, ro_ld_reg1=1; next cycle V_ro=1, in3=3, in3_needed=1 → dep_stall=1, gpr_busy=8'h08. wb_fire with wb_dreg1=3 → dep_stall=0 from the following cycle.
3. Same-cycle inc/dec: count GPR2=1; issue dreg=2 and retire dreg=2 together → gpr_busy[2] stays 1, count=1. Duplicate ro_dreg1=ro_dreg2=2 issue → count +1 only.
4. Saturation: three issues to MM4 (count=3), then V_ro=1 with ro_dmm=4, ro_ld_mm=1 → dep_stall=1 with no source needed. One retire → dep_stall=0.
5. Flush and underflow: counts GPR0=2, SEG1=1; flush together with issue of GPR0 → all counters 0 next cycle. Then wb_fire with wb_dseg=1 → sb_err=1, sticky until rst.
6. Implicit sources: issue dreg=1; V_ro=1, ecx_needed=1 → dep_stall=1; eax_needed alone → dep_stall=0.

Source files
------------

// File: rtl/ro_dep_scoreboard_pkg.sv
// ro_pkg: shared register-index constants, destination bundle type and
// a one-hot decode helper for the RO in-flight write scoreboard.
`default_nettype none

package ro_pkg;

  localparam int REG_IDX_W = 3;
  localparam int NREG      = 8;

  localparam logic [REG_IDX_W-1:0] GPR_EAX = 3'd0;
  localparam logic [REG_IDX_W-1:0] GPR_ECX = 3'd1;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic                 valid;
  } dest_t;

  // OR-ing these per destination collapses duplicates into a single bit.
  function automatic logic [NREG-1:0] dest_onehot(input dest_t d);
    logic [NREG-1:0] oh;
    oh = '0;
    if (d.valid) oh[d.idx] = 1'b1;
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ro_dep_scoreboard_if.sv
// RO/WB destination and source bundle for the in-flight write scoreboard.
`default_nettype none

interface ro_dep_scoreboard_if;
  import ro_pkg::*;

  logic                 V_ro;
  logic [REG_IDX_W-1:0] in3, in4;
  logic                 in3_needed, in4_needed;
  logic                 eax_needed, ecx_needed;
  logic [REG_IDX_W-1:0] mm1, mm2;
  logic                 mm1_needed, mm2_needed;
  logic [REG_IDX_W-1:0] seg3;
  logic                 seg3_needed;

  logic                 issue_fire;
  logic [REG_IDX_W-1:0] ro_dreg1, ro_dreg2, ro_dreg3;
  logic                 ro_ld_reg1, ro_ld_reg2, ro_ld_reg3;
  logic [REG_IDX_W-1:0] ro_dmm, ro_dseg;
  logic                 ro_ld_mm, ro_ld_seg;

  logic                 wb_fire;
  logic [REG_IDX_W-1:0] wb_dreg1, wb_dreg2, wb_dreg3;
  logic                 wb_ld_reg1, wb_ld_reg2, wb_ld_reg3;
  logic [REG_IDX_W-1:0] wb_dmm, wb_dseg;
  logic                 wb_ld_mm, wb_ld_seg;

  logic                 flush;

  logic                 dep_stall;
  logic [NREG-1:0]      gpr_busy, mm_busy, seg_busy;
  logic                 sb_err;

  modport master (
    output V_ro, in3, in4, in3_needed, in4_needed, eax_needed, ecx_needed,
           mm1, mm2, mm1_needed, mm2_needed, seg3, seg3_needed,
           issue_fire, ro_dreg1, ro_dreg2, ro_dreg3,
           ro_ld_reg1, ro_ld_reg2, ro_ld_reg3, ro_dmm, ro_ld_mm, ro_dseg, ro_ld_seg,
           wb_fire, wb_dreg1, wb_dreg2, wb_dreg3,
           wb_ld_reg1, wb_ld_reg2, wb_ld_reg3, wb_dmm, wb_ld_mm, wb_dseg, wb_ld_seg,
           flush,
    input  dep_stall, gpr_busy, mm_busy, seg_busy, sb_err
  );

  modport slave (
    input  V_ro, in3, in4, in3_needed, in4_needed, eax_needed, ecx_needed,
           mm1, mm2, mm1_needed, mm2_needed, seg3, seg3_needed,
           issue_fire, ro_dreg1, ro_dreg2, ro_dreg3,
           ro_ld_reg1, ro_ld_reg2, ro_ld_reg3, ro_dmm, ro_ld_mm, ro_dseg, ro_ld_seg,
           wb_fire, wb_dreg1, wb_dreg2, wb_dreg3,
           wb_ld_reg1, wb_ld_reg2, wb_ld_reg3, wb_dmm, wb_ld_mm, wb_dseg, wb_ld_seg,
           flush,
    output dep_stall, gpr_busy, mm_busy, seg_busy, sb_err
  );

endinterface

`default_nettype wire

// File: rtl/ro_dep_scoreboard_counter.sv
// ro_sb_counter: one per-register in-flight write counter with flush
// priority and an underflow strobe for retire-without-issue.
`default_nettype none

module ro_sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (inc && !dec)
      count_nxt = count + 1'b1;
    else if (dec && !inc && (count != '0))
      count_nxt = count - 1'b1;
  end

  assign underflow = !flush && dec && !inc && (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= count_nxt;
  end

endmodule

`default_nettype wire

// File: rtl/ro_dep_scoreboard.sv
// ro_dep_scoreboard: per-register in-flight write counters for GPR/MM/SEG
// that generate the RO dependency stall without EX/WB destination compares.
`default_nettype none

module ro_dep_scoreboard
  import ro_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  ro_dep_scoreboard_if.slave  sb
);

  logic [NREG-1:0] gpr_inc, mm_inc, seg_inc;
  logic [NREG-1:0] gpr_dec, mm_dec, seg_dec;
  logic [NREG-1:0] gpr_uf,  mm_uf,  seg_uf;
  logic [NREG-1:0] gpr_full, mm_full, seg_full;
  logic [NREG-1:0] gpr_busy, mm_busy, seg_busy;
  logic [NREG-1:0][CNT_W-1:0] gpr_cnt, mm_cnt, seg_cnt;
  logic hazard, sat, sb_err_q;

  assign gpr_inc = {NREG{sb.issue_fire}} &
                   (dest_onehot('{idx: sb.ro_dreg1, valid: sb.ro_ld_reg1}) |
                    dest_onehot('{idx: sb.ro_dreg2, valid: sb.ro_ld_reg2}) |
                    dest_onehot('{idx: sb.ro_dreg3, valid: sb.ro_ld_reg3}));
  assign mm_inc  = {NREG{sb.issue_fire}} & dest_onehot('{idx: sb.ro_dmm,  valid: sb.ro_ld_mm});
  assign seg_inc = {NREG{sb.issue_fire}} & dest_onehot('{idx: sb.ro_dseg, valid: sb.ro_ld_seg});

  assign gpr_dec = {NREG{sb.wb_fire}} &
                   (dest_onehot('{idx: sb.wb_dreg1, valid: sb.wb_ld_reg1}) |
                    dest_onehot('{idx: sb.wb_dreg2, valid: sb.wb_ld_reg2}) |
                    dest_onehot('{idx: sb.wb_dreg3, valid: sb.wb_ld_reg3}));
  assign mm_dec  = {NREG{sb.wb_fire}} & dest_onehot('{idx: sb.wb_dmm,  valid: sb.wb_ld_mm});
  assign seg_dec = {NREG{sb.wb_fire}} & dest_onehot('{idx: sb.wb_dseg, valid: sb.wb_ld_seg});

  for (genvar i = 0; i < NREG; i++) begin : g_cnt
    ro_sb_counter #(.CNT_W(CNT_W)) u_gpr (
      .clk(clk), .rst(rst), .flush(sb.flush), .inc(gpr_inc[i]), .dec(gpr_dec[i]),
      .count(gpr_cnt[i]), .underflow(gpr_uf[i]));
    ro_sb_counter #(.CNT_W(CNT_W)) u_mm (
      .clk(clk), .rst(rst), .flush(sb.flush), .inc(mm_inc[i]), .dec(mm_dec[i]),
      .count(mm_cnt[i]), .underflow(mm_uf[i]));
    ro_sb_counter #(.CNT_W(CNT_W)) u_seg (
      .clk(clk), .rst(rst), .flush(sb.flush), .inc(seg_inc[i]), .dec(seg_dec[i]),
      .count(seg_cnt[i]), .underflow(seg_uf[i]));

    assign gpr_busy[i] = |gpr_cnt[i];
    assign mm_busy[i]  = |mm_cnt[i];
    assign seg_busy[i] = |seg_cnt[i];
    assign gpr_full[i] = &gpr_cnt[i];
    assign mm_full[i]  = &mm_cnt[i];
    assign seg_full[i] = &seg_cnt[i];
  end

  // Registered counts only: a retiring write releases the stall one cycle later.
  assign hazard = sb.V_ro &
                  ((sb.in3_needed  && gpr_busy[sb.in3])  ||
                   (sb.in4_needed  && gpr_busy[sb.in4])  ||
                   (sb.eax_needed  && gpr_busy[GPR_EAX]) ||
                   (sb.ecx_needed  && gpr_busy[GPR_ECX]) ||
                   (sb.mm1_needed  && mm_busy[sb.mm1])   ||
                   (sb.mm2_needed  && mm_busy[sb.mm2])   ||
                   (sb.seg3_needed && seg_busy[sb.seg3]));

  // Holding issue on a full counter is what keeps the increment from wrapping.
  assign sat = sb.V_ro &
               ((sb.ro_ld_reg1 && gpr_full[sb.ro_dreg1]) ||
                (sb.ro_ld_reg2 && gpr_full[sb.ro_dreg2]) ||
                (sb.ro_ld_reg3 && gpr_full[sb.ro_dreg3]) ||
                (sb.ro_ld_mm   && mm_full[sb.ro_dmm])    ||
                (sb.ro_ld_seg  && seg_full[sb.ro_dseg]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sb_err_q <= 1'b0;
    else if (|{gpr_uf, mm_uf, seg_uf})
      sb_err_q <= 1'b1;
  end

  assign sb.dep_stall = hazard | sat;
  assign sb.gpr_busy  = gpr_busy;
  assign sb.mm_busy   = mm_busy;
  assign sb.seg_busy  = seg_busy;
  assign sb.sb_err    = sb_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ro_dep_scoreboard.sv
// Directed self-checking bench for ro_dep_scoreboard: hazards, same-cycle
// inc/dec, duplicate collapse, saturation, flush, underflow and async reset.
`default_nettype none

module tb_ro_dep_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ro_dep_scoreboard_if sb_if ();

  ro_dep_scoreboard #(.CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    sb_if.V_ro = 0; sb_if.in3 = 0; sb_if.in4 = 0; sb_if.in3_needed = 0; sb_if.in4_needed = 0;
    sb_if.eax_needed = 0; sb_if.ecx_needed = 0; sb_if.mm1 = 0; sb_if.mm2 = 0;
    sb_if.mm1_needed = 0; sb_if.mm2_needed = 0; sb_if.seg3 = 0; sb_if.seg3_needed = 0;
    sb_if.issue_fire = 0; sb_if.ro_dreg1 = 0; sb_if.ro_dreg2 = 0; sb_if.ro_dreg3 = 0;
    sb_if.ro_ld_reg1 = 0; sb_if.ro_ld_reg2 = 0; sb_if.ro_ld_reg3 = 0;
    sb_if.ro_dmm = 0; sb_if.ro_ld_mm = 0; sb_if.ro_dseg = 0; sb_if.ro_ld_seg = 0;
    sb_if.wb_fire = 0; sb_if.wb_dreg1 = 0; sb_if.wb_dreg2 = 0; sb_if.wb_dreg3 = 0;
    sb_if.wb_ld_reg1 = 0; sb_if.wb_ld_reg2 = 0; sb_if.wb_ld_reg3 = 0;
    sb_if.wb_dmm = 0; sb_if.wb_ld_mm = 0; sb_if.wb_dseg = 0; sb_if.wb_ld_seg = 0;
    sb_if.flush = 0;
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_gpr(input logic [2:0] d);
    clear_inputs();
    sb_if.issue_fire = 1; sb_if.ro_dreg1 = d; sb_if.ro_ld_reg1 = 1;
    tick();
    clear_inputs();
  endtask

  task automatic retire_gpr(input logic [2:0] d);
    clear_inputs();
    sb_if.wb_fire = 1; sb_if.wb_dreg1 = d; sb_if.wb_ld_reg1 = 1;
    tick();
    clear_inputs();
  endtask

  task automatic issue_mm(input logic [2:0] d);
    clear_inputs();
    sb_if.issue_fire = 1; sb_if.ro_dmm = d; sb_if.ro_ld_mm = 1;
    tick();
    clear_inputs();
  endtask

  task automatic retire_mm(input logic [2:0] d);
    clear_inputs();
    sb_if.wb_fire = 1; sb_if.wb_dmm = d; sb_if.wb_ld_mm = 1;
    tick();
    clear_inputs();
  endtask

  initial begin
    // 1. reset with a source requested
    clear_inputs();
    sb_if.V_ro = 1; sb_if.in3 = 3'd5; sb_if.in3_needed = 1;
    #1;
    check("rst_gpr_busy", sb_if.gpr_busy, 8'h00);
    check("rst_mm_busy",  sb_if.mm_busy,  8'h00);
    check("rst_seg_busy", sb_if.seg_busy, 8'h00);
    check("rst_dep_stall", {7'b0, sb_if.dep_stall}, 8'h00);
    check("rst_sb_err",   {7'b0, sb_if.sb_err}, 8'h00);
    tick();
    rst = 0;
    tick();
    check("idle_dep_stall", {7'b0, sb_if.dep_stall}, 8'h00);

    // 2. RAW on GPR3, no WB bypass
    issue_gpr(3'd3);
    sb_if.V_ro = 1; sb_if.in3 = 3'd3; sb_if.in3_needed = 1;
    #1;
    check("raw_stall", {7'b0, sb_if.dep_stall}, 8'h01);
    check("raw_busy", sb_if.gpr_busy, 8'h08);
    sb_if.wb_fire = 1; sb_if.wb_dreg1 = 3'd3; sb_if.wb_ld_reg1 = 1;
    #1;
    check("raw_no_bypass", {7'b0, sb_if.dep_stall}, 8'h01);
    tick();
    sb_if.wb_fire = 0; sb_if.wb_ld_reg1 = 0;
    #1;
    check("raw_release", {7'b0, sb_if.dep_stall}, 8'h00);
    check("raw_busy_clr", sb_if.gpr_busy, 8'h00);
    clear_inputs();

    // 3. same-cycle inc/dec and duplicate collapse on GPR2
    issue_gpr(3'd2);
    check("gpr2_busy", sb_if.gpr_busy, 8'h04);
    sb_if.issue_fire = 1; sb_if.ro_dreg1 = 3'd2; sb_if.ro_ld_reg1 = 1;
    sb_if.wb_fire = 1; sb_if.wb_dreg2 = 3'd2; sb_if.wb_ld_reg2 = 1;
    tick();
    clear_inputs();
    check("incdec_busy", sb_if.gpr_busy, 8'h04);
    sb_if.issue_fire = 1; sb_if.ro_dreg1 = 3'd2; sb_if.ro_ld_reg1 = 1;
    sb_if.ro_dreg2 = 3'd2; sb_if.ro_ld_reg2 = 1;
    tick();
    clear_inputs();
    retire_gpr(3'd2);
    check("dup_after_ret1", sb_if.gpr_busy, 8'h04);
    retire_gpr(3'd2);
    check("dup_after_ret2", sb_if.gpr_busy, 8'h00);
    check("dup_no_err", {7'b0, sb_if.sb_err}, 8'h00);

    // 4. saturation on MM4
    issue_mm(3'd4);
    issue_mm(3'd4);
    sb_if.V_ro = 1; sb_if.ro_dmm = 3'd4; sb_if.ro_ld_mm = 1;
    #1;
    check("sat_cnt2_no_stall", {7'b0, sb_if.dep_stall}, 8'h00);
    issue_mm(3'd4);
    check("sat_mm_busy", sb_if.mm_busy, 8'h10);
    sb_if.V_ro = 1; sb_if.ro_dmm = 3'd4; sb_if.ro_ld_mm = 1;
    #1;
    check("sat_stall", {7'b0, sb_if.dep_stall}, 8'h01);
    sb_if.V_ro = 0;
    #1;
    check("sat_needs_vro", {7'b0, sb_if.dep_stall}, 8'h00);
    retire_mm(3'd4);
    sb_if.V_ro = 1; sb_if.ro_dmm = 3'd4; sb_if.ro_ld_mm = 1;
    #1;
    check("sat_release", {7'b0, sb_if.dep_stall}, 8'h00);
    clear_inputs();
    sb_if.V_ro = 1; sb_if.mm2 = 3'd4; sb_if.mm2_needed = 1;
    #1;
    check("mm2_hazard", {7'b0, sb_if.dep_stall}, 8'h01);
    retire_mm(3'd4);
    retire_mm(3'd4);
    check("mm_drained", sb_if.mm_busy, 8'h00);

    // 5. flush then underflow
    issue_gpr(3'd0);
    sb_if.issue_fire = 1; sb_if.ro_dreg1 = 3'd0; sb_if.ro_ld_reg1 = 1;
    sb_if.ro_dseg = 3'd1; sb_if.ro_ld_seg = 1;
    tick();
    clear_inputs();
    check("pre_flush_gpr", sb_if.gpr_busy, 8'h01);
    check("pre_flush_seg", sb_if.seg_busy, 8'h02);
    sb_if.V_ro = 1; sb_if.seg3 = 3'd1; sb_if.seg3_needed = 1;
    #1;
    check("seg_hazard", {7'b0, sb_if.dep_stall}, 8'h01);
    clear_inputs();
    sb_if.flush = 1; sb_if.issue_fire = 1; sb_if.ro_dreg1 = 3'd0; sb_if.ro_ld_reg1 = 1;
    tick();
    clear_inputs();
    check("flush_gpr", sb_if.gpr_busy, 8'h00);
    check("flush_seg", sb_if.seg_busy, 8'h00);
    check("flush_no_err", {7'b0, sb_if.sb_err}, 8'h00);
    sb_if.wb_fire = 1; sb_if.wb_dseg = 3'd1; sb_if.wb_ld_seg = 1;
    tick();
    clear_inputs();
    check("uf_err", {7'b0, sb_if.sb_err}, 8'h01);
    check("uf_seg_stays0", sb_if.seg_busy, 8'h00);
    tick();
    tick();
    check("uf_sticky", {7'b0, sb_if.sb_err}, 8'h01);
    rst = 1;
    #1;
    check("uf_rst_clears", {7'b0, sb_if.sb_err}, 8'h00);
    tick();
    rst = 0;

    // 6. implicit EAX/ECX sources
    issue_gpr(3'd1);
    sb_if.V_ro = 1; sb_if.ecx_needed = 1;
    #1;
    check("ecx_hazard", {7'b0, sb_if.dep_stall}, 8'h01);
    sb_if.ecx_needed = 0; sb_if.eax_needed = 1;
    #1;
    check("eax_clear", {7'b0, sb_if.dep_stall}, 8'h00);
    sb_if.eax_needed = 0; sb_if.in4 = 3'd1; sb_if.in4_needed = 1;
    #1;
    check("in4_hazard", {7'b0, sb_if.dep_stall}, 8'h01);
    clear_inputs();

    // async reset mid-cycle clears counters without a clock edge
    @(negedge clk);
    rst = 1;
    #1;
    check("async_rst_busy", sb_if.gpr_busy, 8'h00);
    tick();
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
